// File: rtl/bcd_stopwatch_ctrl_if.sv
// Button inputs and display outputs of the BCD stopwatch.
// The master drives the buttons; the slave drives the display.
interface bcd_stopwatch_ctrl_if;
  logic       btn_start;
  logic       btn_clear;
  logic [7:0] hex0;
  logic [7:0] hex1;
  logic       running;
  logic       wrap;

  modport master (
    output btn_start,
    output btn_clear,
    input  hex0,
    input  hex1,
    input  running,
    input  wrap
  );

  modport slave (
    input  btn_start,
    input  btn_clear,
    output hex0,
    output hex1,
    output running,
    output wrap
  );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// Two-digit BCD stopwatch: debounced start/clear buttons, an
// IDLE/RUN/PAUSE sequencer, a prescaled 00-99 counter and 7-seg decode.
module bcd_stopwatch_ctrl #(
  parameter int TICK_DIV = 5000000,
  parameter int DEB_DIV  = 65536
) (
  input logic                 clk,
  input logic                 rst,
  bcd_stopwatch_ctrl_if.slave bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  logic [1:0]    sync_s_q, sync_c_q;
  logic [DW-1:0] deb_q, deb_d;
  logic          smp_s_q, smp_c_q;
  logic          prv_s_q, prv_c_q;
  logic          stb_q;
  logic          strobe;
  logic          start_evt, clear_evt;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] pre_q, pre_d;
  logic [3:0]    d0_q, d0_d;
  logic [3:0]    d1_q, d1_d;
  logic          running_q;
  logic          wrap_q, wrap_d;
  logic          tick;

  assign strobe = (deb_q == DEB_LAST);
  assign deb_d  = strobe ? '0 : deb_q + 1'b1;

  // stb_q marks the single cycle in which a fresh sample pair is visible
  assign start_evt = stb_q & prv_s_q & ~smp_s_q;
  assign clear_evt = stb_q & prv_c_q & ~smp_c_q;

  assign tick = (state_q == RUN) && (pre_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    wrap_d  = 1'b0;
    if (clear_evt) begin
      state_d = IDLE;
      pre_d   = '0;
      d0_d    = 4'd0;
      d1_d    = 4'd0;
    end else begin
      if (state_q == RUN) begin
        pre_d = tick ? '0 : pre_q + 1'b1;
      end
      if (tick) begin
        if (d0_q == 4'd9) begin
          d0_d = 4'd0;
          if (d1_q == 4'd9) begin
            d1_d   = 4'd0;
            wrap_d = 1'b1;
          end else begin
            d1_d = d1_q + 4'd1;
          end
        end else begin
          d0_d = d0_q + 4'd1;
        end
      end
      if (start_evt) begin
        case (state_q)
          IDLE:    state_d = RUN;
          RUN:     state_d = PAUSE;
          PAUSE:   state_d = RUN;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_s_q  <= 2'b11;
      sync_c_q  <= 2'b11;
      deb_q     <= '0;
      smp_s_q   <= 1'b1;
      smp_c_q   <= 1'b1;
      prv_s_q   <= 1'b1;
      prv_c_q   <= 1'b1;
      stb_q     <= 1'b0;
      state_q   <= IDLE;
      pre_q     <= '0;
      d0_q      <= 4'd0;
      d1_q      <= 4'd0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      sync_s_q  <= {sync_s_q[0], bus.btn_start};
      sync_c_q  <= {sync_c_q[0], bus.btn_clear};
      deb_q     <= deb_d;
      stb_q     <= strobe;
      if (strobe) begin
        smp_s_q <= sync_s_q[1];
        smp_c_q <= sync_c_q[1];
        prv_s_q <= smp_s_q;
        prv_c_q <= smp_c_q;
      end
      state_q   <= state_d;
      pre_q     <= pre_d;
      d0_q      <= d0_d;
      d1_q      <= d1_d;
      running_q <= (state_d == RUN);
      wrap_q    <= wrap_d;
    end
  end

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h98;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  assign bus.hex0    = seg7(d0_q);
  assign bus.hex1    = seg7(d1_q);
  assign bus.running = running_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Randomised bench for bcd_stopwatch_ctrl: an integer-count reference
// model feeds an expectation queue that a negedge monitor drains.
module tb_bcd_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
  localparam int DEB_DIV  = 2;

  localparam logic [7:0] SEG [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h98
  };

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bcd_stopwatch_ctrl_if bus();

  bcd_stopwatch_ctrl #(
    .TICK_DIV(TICK_DIV),
    .DEB_DIV (DEB_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] h0;
    logic [7:0] h1;
    logic       run;
    logic       wrp;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int wraps  = 0;

  // reference model: m_st 0=idle 1=run 2=pause, m_cnt is the 0..99 value
  int m_st, m_pre, m_cnt, m_phase;
  bit m_wrap;
  bit ss0, ss1, sc0, sc1;
  bit ms_s, ms_c;
  bit ev_s, ev_c;

  always @(posedge clk) begin
    bit tick, strobe, nev_s, nev_c;
    if (rst) begin
      m_st = 0; m_pre = 0; m_cnt = 0; m_phase = 0;
      m_wrap = 0;
      ss0 = 1; ss1 = 1; sc0 = 1; sc1 = 1;
      ms_s = 1; ms_c = 1;
      ev_s = 0; ev_c = 0;
    end else begin
      tick = (m_st == 1) && (m_pre == TICK_DIV - 1);
      m_wrap = 0;
      if (ev_c) begin
        m_st = 0; m_cnt = 0; m_pre = 0;
      end else begin
        if (tick) begin
          m_wrap = (m_cnt == 99);
          m_cnt = (m_cnt + 1) % 100;
        end
        if (m_st == 1) m_pre = (m_pre + 1) % TICK_DIV;
        if (ev_s) m_st = (m_st == 1) ? 2 : 1;
      end
      strobe = (m_phase == DEB_DIV - 1);
      m_phase = (m_phase + 1) % DEB_DIV;
      nev_s = strobe && ms_s && !ss1;
      nev_c = strobe && ms_c && !sc1;
      if (strobe) begin
        ms_s = ss1;
        ms_c = sc1;
      end
      ss1 = ss0; ss0 = bus.btn_start;
      sc1 = sc0; sc0 = bus.btn_clear;
      ev_s = nev_s;
      ev_c = nev_c;
    end
    exp_q.push_back('{SEG[m_cnt % 10], SEG[m_cnt / 10], m_st == 1, m_wrap});
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.hex1, bus.hex0, bus.running, bus.wrap} !==
          {e.h1, e.h0, e.run, e.wrp}) begin
        errors++;
        if (errors <= 20)
          $display("FAIL scoreboard @%0t: got hex1=%h hex0=%h run=%b wrap=%b, expected %h %h %b %b",
                   $time, bus.hex1, bus.hex0, bus.running, bus.wrap,
                   e.h1, e.h0, e.run, e.wrp);
      end
      if (bus.wrap === 1'b1) wraps++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int lat;
    int w0;
    int sel;
    rst = 1'b1;
    bus.btn_start = 1'b1;
    bus.btn_clear = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(50);
    chk("reset_hex0", bus.hex0, 8'hC0);
    chk("reset_hex1", bus.hex1, 8'hC0);
    chk("reset_running", bus.running, 0);
    chk("reset_wrap", bus.wrap, 0);

    // long hold must yield a single start event
    bus.btn_start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (lat < 0 && bus.running === 1'b1) lat = i;
    end
    chk("start_latency", (lat >= 1 && lat <= 6), 1);
    bus.btn_start = 1'b1;
    cyc(40);
    chk("run_after_hold", bus.running, 1);

    bus.btn_start = 1'b0;
    bus.btn_clear = 1'b0;
    cyc(8);
    bus.btn_start = 1'b1;
    bus.btn_clear = 1'b1;
    cyc(4);
    chk("clear_both_run", bus.running, 0);
    chk("clear_both_hex0", bus.hex0, 8'hC0);
    chk("clear_both_hex1", bus.hex1, 8'hC0);

    bus.btn_start = 1'b0;
    cyc(3);
    bus.btn_start = 1'b1;
    w0 = wraps;
    cyc(450);
    chk("wrap_once", wraps - w0, 1);
    chk("wrap_running", bus.running, 1);

    rst = 1'b1;
    repeat (3) begin
      bus.btn_start = 1'($urandom);
      bus.btn_clear = 1'($urandom);
      cyc(1);
    end
    bus.btn_start = 1'b1;
    bus.btn_clear = 1'b1;
    rst = 1'b0;
    chk("midrst_run", bus.running, 0);
    chk("midrst_hex0", bus.hex0, 8'hC0);
    chk("midrst_wrap", bus.wrap, 0);
    cyc(20);
    chk("midrst_idle", bus.running, 0);
    chk("midrst_hex1", bus.hex1, 8'hC0);

    for (int k = 0; k < 80; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 4) begin
        bus.btn_start = 1'b0;
        cyc(int'($urandom_range(1, 12)));
        bus.btn_start = 1'b1;
      end else if (sel == 5) begin
        bus.btn_clear = 1'b0;
        cyc(int'($urandom_range(1, 8)));
        bus.btn_clear = 1'b1;
      end else if (sel == 6) begin
        bus.btn_start = 1'b0;
        bus.btn_clear = 1'b0;
        cyc(int'($urandom_range(1, 8)));
        bus.btn_start = 1'b1;
        bus.btn_clear = 1'b1;
      end else if (sel == 7 && k % 4 == 0) begin
        rst = 1'b1;
        cyc(int'($urandom_range(1, 2)));
        rst = 1'b0;
      end
      cyc(int'($urandom_range(0, 120)));
    end
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
